// File: rtl/cla_seq_pkg.sv
// Shared constants, state encoding and lane-count helper for the sequential wide adder.
package cla_seq_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int lane_count(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/cla_slice8.sv
// Combinational 8-bit carry-lookahead slice; every carry is a flat sum of generate/propagate products.
module cla_slice8
  import cla_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic term;
    logic prop;
    c    = '0;
    term = 1'b0;
    prop = 1'b0;
    c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      term = g[i];
      prop = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = term | (prop & cin);
    end
  end

  assign s  = p ^ c[SLICE_W-1:0];
  assign co = c[SLICE_W];

endmodule

// File: rtl/cla_seq_adder.sv
// Wide adder reusing one 8-bit CLA slice per byte lane; done pulses N+1 cycles after acceptance, new
// starts are ignored while busy. CLA_SEQ_SUB_EN adds a sub port for a - b.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = lane_count(WIDTH);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_e             state;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;

  logic [WIDTH-1:0]   b_acc;
  logic               c_acc;
  logic [SLICE_W-1:0] lane_a;
  logic [SLICE_W-1:0] lane_b;
  logic [SLICE_W-1:0] lane_s;
  logic               lane_co;

`ifdef CLA_SEQ_SUB_EN
  // Two's-complement subtract: invert b and force the initial carry.
  assign b_acc = sub ? ~b : b;
  assign c_acc = sub | cin;
`else
  assign b_acc = b;
  assign c_acc = cin;
`endif

  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == i[IDX_W-1:0]) begin
        lane_a = a_q[i*SLICE_W +: SLICE_W];
        lane_b = b_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  cla_slice8 u_slice (
    .a   (lane_a),
    .b   (lane_b),
    .cin (carry_q),
    .s   (lane_s),
    .co  (lane_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b_acc;
            carry_q <= c_acc;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < N; i++) begin
            if (idx == i[IDX_W-1:0]) sum[i*SLICE_W +: SLICE_W] <= lane_s;
          end
          carry_q <= lane_co;
          if (idx == LAST) begin
            // Flags settle with the MSB lane so they are valid during the done cycle.
            cout  <= lane_co;
            ovf   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (lane_s[SLICE_W-1] != a_q[WIDTH-1]);
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed scoreboard bench for cla_seq_adder at WIDTH=32.
module tb_cla_seq_adder;

  localparam int W = 32;
  localparam int N = W / 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         ready;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef CLA_SEQ_SUB_EN
    .sub   (sub),
`endif
    .ready (ready),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one request; returns one step after the acceptance edge.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                        input logic ts, input bit push);
    logic [W-1:0] beff;
    logic         ceff;
    logic [W:0]   full;
    exp_t         e;
    int           guard;
    guard = 0;
    while (!ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ready_before_start", {63'd0, ready}, 64'd1);
    beff = tbv;
    ceff = tc;
`ifdef CLA_SEQ_SUB_EN
    if (ts) begin
      beff = ~tbv;
      ceff = 1'b1;
    end
`endif
    full = {1'b0, ta} + {1'b0, beff} + {{W{1'b0}}, ceff};
    e.s  = full[W-1:0];
    e.co = full[W];
    e.ov = (ta[W-1] == beff[W-1]) && (full[W-1] != ta[W-1]);
    if (push) sb.push_back(e);
    a = ta; b = tbv; cin = tc; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges from acceptance (acceptance edge = 1) until done, then scores the result.
  task automatic collect(input string tag, input int already);
    int   lat;
    exp_t e;
    lat = already;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(N + 1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_sum"}, 64'(sum), 64'(e.s));
      check({tag, "_cout"}, {63'd0, cout}, {63'd0, e.co});
      check({tag, "_ovf"}, {63'd0, ovf}, {63'd0, e.ov});
    end else begin
      check({tag, "_scoreboard_nonempty"}, 64'd0, 64'd1);
    end
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
    check({tag, "_ready_back"}, {63'd0, ready}, 64'd1);
  endtask

  initial begin
    int pulses;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    launch(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    collect("lane_carry", 1);

    launch(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    collect("full_ripple", 1);

    launch(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    collect("signed_ovf", 1);

    launch(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    collect("neg_ovf", 1);

    // Start pulsed mid-operation must be ignored.
    launch(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; cin = 1'b1; start = 1'b1;
    check("busy_not_ready", {63'd0, ready}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    collect("ignore_start", 3);
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("ignored_start_no_extra_done", 64'(pulses), 64'd0);

`ifdef CLA_SEQ_SUB_EN
    launch(32'd5, 32'd7, 1'b0, 1'b1, 1'b1);
    collect("sub_borrow", 1);
    launch(32'd7, 32'd5, 1'b0, 1'b1, 1'b1);
    collect("sub_noborrow", 1);
`endif

    // Abort mid-RUN with reset.
    launch(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", {63'd0, ready}, 64'd1);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    check("abort_cout", {63'd0, cout}, 64'd0);
    check("abort_ovf", {63'd0, ovf}, 64'd0);
    rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);

    launch(32'hFFFF_FF00, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
    collect("after_abort", 1);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
